// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, a registered in_ready
// and a one-entry skid register so upstream never sees a combinational ready path.
//
// state   | meaning
// --------+------------------------------------------------
// S_EMPTY | bubble: nothing held, out_ctrl forced to 0
// S_ONE   | main holds the head entry, skid unused
// S_TWO   | main holds the head, skid holds the younger entry
module pipe_stage_skid #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o
);

   typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic              accept;

   assign accept = in_valid_i & in_ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_EMPTY;
         in_ready_q  <= 1'b1;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      case (state_q)
         S_EMPTY: begin
            if (accept) begin
               state_d     = S_ONE;
               main_ctrl_d = in_ctrl_i;
               main_data_d = in_data_i;
            end
         end
         S_ONE: begin
            if (accept && out_ready_i) begin
               main_ctrl_d = in_ctrl_i;
               main_data_d = in_data_i;
            end else if (accept) begin
               state_d     = S_TWO;
               skid_ctrl_d = in_ctrl_i;
               skid_data_d = in_data_i;
            end else if (out_ready_i) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (out_ready_i) begin
               state_d     = S_ONE;
               main_ctrl_d = skid_ctrl_q;
               main_data_d = skid_data_q;
               skid_ctrl_d = '0;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      // Flush discards everything, including the input offered this cycle;
      // payload registers keep their old contents since data is never cleared.
      if (flush_i) begin
         state_d     = S_EMPTY;
         main_data_d = main_data_q;
         skid_data_d = skid_data_q;
      end
      if (state_d == S_EMPTY) begin
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end
      in_ready_d = (state_d != S_TWO);
   end

   always_comb begin
      out_valid_o = 1'b0;
      occupancy_o = 2'd0;
      case (state_q)
         S_ONE: begin
            out_valid_o = 1'b1;
            occupancy_o = 2'd1;
         end
         S_TWO: begin
            out_valid_o = 1'b1;
            occupancy_o = 2'd2;
         end
         default: begin
            out_valid_o = 1'b0;
            occupancy_o = 2'd0;
         end
      endcase
   end

   assign in_ready_o = in_ready_q;
   assign out_ctrl_o = main_ctrl_q;
   assign out_data_o = main_data_q;

endmodule
